// File: rtl/ptcalc_rescale_pkg.sv
// ptcalc_rescale_pkg
//   Shared constants, types and helpers for the ptcalc product rescale block.
//   PROD_W_C / SHIFT_C / OUT_W_C : default product width, dropped fraction
//                                  bits and output width.
//   prod_t / pt_t                : signed product and pT word types.
//   sat_limits(out_w)            : signed max/min of an out_w-bit word,
//                                  returned as 64-bit two's complement.
package ptcalc_rescale_pkg;

  localparam int PROD_W_C = 42;
  localparam int SHIFT_C  = 16;
  localparam int OUT_W_C  = 16;

  typedef logic signed [PROD_W_C-1:0] prod_t;
  typedef logic signed [OUT_W_C-1:0]  pt_t;

  typedef struct packed {
    logic [63:0] max_v;
    logic [63:0] min_v;
  } sat_lim_t;

  // max = 2^(out_w-1)-1, min = -2^(out_w-1) = ~max in two's complement.
  function automatic sat_lim_t sat_limits(input int out_w);
    sat_lim_t lim;
    lim.max_v = (64'd1 << (out_w - 1)) - 64'd1;
    lim.min_v = ~lim.max_v;
    return lim;
  endfunction

endpackage

// File: rtl/ptcalc_round_shift.sv
// ptcalc_round_shift
//   Combinational rounding shifter: r = (prod + 2^(SHIFT-1)) >>> SHIFT,
//   evaluated one bit wider than the product so the rounding add cannot
//   overflow. Ties therefore round toward +inf (-0.5 -> 0).
//   SHIFT = 0 passes the product through sign-extended, with no rounding.
//   Ports:
//     prod  in  PROD_W    signed product
//     r     out PROD_W+1  rounded, shifted result
module ptcalc_round_shift
  import ptcalc_rescale_pkg::*;
#(
  parameter int PROD_W = PROD_W_C,
  parameter int SHIFT  = SHIFT_C
) (
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [PROD_W:0]   r
);

  logic signed [PROD_W:0] ext;
  assign ext = {prod[PROD_W-1], prod};

  generate
    if (SHIFT == 0) begin : g_pass
      assign r = ext;
    end else begin : g_round
      localparam logic signed [PROD_W:0] HALF = {{PROD_W{1'b0}}, 1'b1} << (SHIFT - 1);
      logic signed [PROD_W:0] sum;
      assign sum = ext + HALF;
      assign r   = sum >>> SHIFT;
    end
  endgenerate

endmodule

// File: rtl/ptcalc_product_rescale.sv
// ptcalc_product_rescale
//   Rescales the signed multiplier product to the pT word: rounding right
//   shift (stage S1), then signed saturation to OUT_W (stage S2, output reg).
//   Two-entry valid/ready pipeline, latency 2, throughput 1/cycle.
//
//   Handshake: a word moves across an interface on a clock edge where both
//   valid and ready are high. A producer holds valid and data steady until
//   that edge; ready may depend combinationally on the consumer's ready.
//
//   Ports:
//     ap_clk        in   clock
//     ap_rst        in   synchronous active-high reset
//     prod_i        in   PROD_W signed product
//     prod_valid_i  in   product valid
//     prod_ready_o  out  block accepts prod_i this cycle
//     pt_o          out  OUT_W rescaled, saturated pT
//     pt_sat_o      out  pt_o was clamped (qualified by pt_valid_o)
//     pt_valid_o    out  pt_o valid
//     pt_ready_i    in   downstream accepts pt_o
//     sat_cnt_o     out  16-bit sticky count of saturated output transfers
//                        (present only with PTCALC_RESCALE_SATCNT_EN defined)
//   Build option: PTCALC_RESCALE_SATCNT_EN adds the saturation counter.
//   Limits are computed in 64 bits, so PROD_W must stay below 64.
module ptcalc_product_rescale
  import ptcalc_rescale_pkg::*;
#(
  parameter int PROD_W = PROD_W_C,
  parameter int SHIFT  = SHIFT_C,
  parameter int OUT_W  = OUT_W_C
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_i,
  input  logic                     prod_valid_i,
  output logic                     prod_ready_o,
  output logic signed [OUT_W-1:0]  pt_o,
  output logic                     pt_sat_o,
  output logic                     pt_valid_o,
  input  logic                     pt_ready_i
`ifdef PTCALC_RESCALE_SATCNT_EN
  ,
  output logic [15:0]              sat_cnt_o
`endif
);

  localparam sat_lim_t LIM = sat_limits(OUT_W);
  localparam logic signed [PROD_W:0] MAX_V = LIM.max_v[PROD_W:0];
  localparam logic signed [PROD_W:0] MIN_V = LIM.min_v[PROD_W:0];

  logic signed [PROD_W:0] r_next;
  logic signed [PROD_W:0] s1_r;
  logic                   s1_valid;
  logic                   s2_load;
  logic                   s1_advance;
  logic                   in_xfer;
  logic signed [OUT_W-1:0] sat_pt;
  logic                   sat_flag;

  ptcalc_round_shift #(
    .PROD_W (PROD_W),
    .SHIFT  (SHIFT)
  ) u_round_shift (
    .prod (prod_i),
    .r    (r_next)
  );

  // S2 can take a word when it is empty or its word leaves this cycle.
  assign s2_load      = !pt_valid_o || pt_ready_i;
  assign s1_advance   = s1_valid && s2_load;
  assign prod_ready_o = !ap_rst && (!s1_valid || s1_advance);
  assign in_xfer      = prod_valid_i && prod_ready_o;

  always_comb begin
    sat_pt   = s1_r[OUT_W-1:0];
    sat_flag = 1'b0;
    if (s1_r > MAX_V) begin
      sat_pt   = MAX_V[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (s1_r < MIN_V) begin
      sat_pt   = MIN_V[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid   <= 1'b0;
      s1_r       <= '0;
      pt_valid_o <= 1'b0;
      pt_o       <= '0;
      pt_sat_o   <= 1'b0;
    end else begin
      // S1: prod_ready_o high means S1 is free this edge.
      if (prod_ready_o) s1_valid <= prod_valid_i;
      if (in_xfer)      s1_r     <= r_next;
      // S2: data only loads on a real word; bubbles clear just the valid.
      if (s2_load) begin
        pt_valid_o <= s1_valid;
        if (s1_valid) begin
          pt_o     <= sat_pt;
          pt_sat_o <= sat_flag;
        end
      end
    end
  end

`ifdef PTCALC_RESCALE_SATCNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_cnt_o <= '0;
    end else if (pt_valid_o && pt_ready_i && pt_sat_o && (sat_cnt_o != 16'hFFFF)) begin
      sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end
`endif

endmodule
